// File: rtl/ram_copy.sv
// ram_copy: block-copy engine acting as initiator on a RAM512 port (copy src->dst, len words).
// Fill mode (write fill_value over dst..dst+len-1) is built only when RAM_COPY_FILL_EN is defined.

module ram_copy #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src,
    input  logic [ADDR_W-1:0] dst,
    input  logic [ADDR_W:0]   len,
    input  logic              fill,
    input  logic [DATA_W-1:0] fill_value,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_in,
    output logic              ram_load,
    input  logic [DATA_W-1:0] ram_out
);

    localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WRITE,
        FILL,
        DONE
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W:0]   idx_q;
    logic [ADDR_W:0]   idx_next;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   len_sat;
    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] dst_q;
    logic [ADDR_W-1:0] src_addr;
    logic [ADDR_W-1:0] dst_addr;
    logic [DATA_W-1:0] data_q;
    logic              accept;
    logic              last;
    logic              fill_mode;

`ifdef RAM_COPY_FILL_EN
    logic [DATA_W-1:0] fill_value_q;

    assign fill_mode = fill;
`else
    logic unused_fill;

    assign fill_mode   = 1'b0;
    assign unused_fill = ^{fill, fill_value};
`endif

    assign len_sat  = (len > MAX_LEN) ? MAX_LEN : len;
    assign accept   = (state_q == IDLE) && start;
    assign idx_next = idx_q + 1'b1;
    assign last     = (idx_next == len_q);
    // Address sums are truncated to ADDR_W bits, giving the 511 -> 0 wrap.
    assign src_addr = src_q + idx_q[ADDR_W-1:0];
    assign dst_addr = dst_q + idx_q[ADDR_W-1:0];

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                idx_q <= '0;
            end else if (ram_load) begin
                idx_q <= idx_next;
            end
        end
    end

    // NOTE: request/data registers carry no reset; they are always written before being used.
    always_ff @(posedge clk) begin
        if (accept) begin
            src_q <= src;
            dst_q <= dst;
            len_q <= len_sat;
`ifdef RAM_COPY_FILL_EN
            fill_value_q <= fill_value;
`endif
        end
        if (state_q == READ) begin
            data_q <= ram_out;
        end
    end

    // NOTE: every output and next-state is defaulted first, so no latch can be inferred.
    always_comb begin
        state_d     = state_q;
        busy        = 1'b0;
        done        = 1'b0;
        ram_address = '0;
        ram_in      = '0;
        ram_load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (len_sat == '0) begin
                        state_d = DONE;
                    end else if (fill_mode) begin
                        state_d = FILL;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ: begin
                busy        = 1'b1;
                ram_address = src_addr;
                state_d     = WRITE;
            end
            WRITE: begin
                busy        = 1'b1;
                ram_address = dst_addr;
                ram_in      = data_q;
                ram_load    = 1'b1;
                state_d     = last ? DONE : READ;
            end
`ifdef RAM_COPY_FILL_EN
            FILL: begin
                busy        = 1'b1;
                ram_address = dst_addr;
                ram_in      = fill_value_q;
                ram_load    = 1'b1;
                state_d     = last ? DONE : FILL;
            end
`endif
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ram_copy.sv
// tb_ram_copy: drives ram_copy against a RAM512 array, predicting every output cycle and the
// final memory image from the transfer rules (sequential word-by-word copy, fixed cycle cadence).

module tb_ram_copy;

`ifdef RAM_COPY_FILL_EN
    localparam bit FILL_EN = 1'b1;
`else
    localparam bit FILL_EN = 1'b0;
`endif

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        load;
        logic [8:0]  addr;
        logic [15:0] din;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [8:0]  src;
    logic [8:0]  dst;
    logic [9:0]  len;
    logic        fill;
    logic [15:0] fill_value;
    logic        busy;
    logic        done;
    logic [8:0]  ram_address;
    logic [15:0] ram_in;
    logic        ram_load;
    logic [15:0] ram_out;

    logic [15:0] mem     [512];
    logic [15:0] ref_mem [512];
    logic        pk_en;
    logic [8:0]  pk_addr;
    logic [15:0] pk_data;

    int   errors = 0;
    int   checks = 0;
    bit   chk_en = 1'b0;
    exp_t exp_q[$];
    exp_t cmp_exp;
    exp_t cmp_act;
    int   cyc;
    int   done_cyc;
    int   done_cnt;
    int   busy_cnt;
    int   load_cnt;
    logic [8:0] addr_log[$];

    ram_copy #(.ADDR_W(9), .DATA_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .src        (src),
        .dst        (dst),
        .len        (len),
        .fill       (fill),
        .fill_value (fill_value),
        .busy       (busy),
        .done       (done),
        .ram_address(ram_address),
        .ram_in     (ram_in),
        .ram_load   (ram_load),
        .ram_out    (ram_out)
    );

    always #5 clk = ~clk;

    // RAM512: combinational read, write on the rising edge; pk_* lets the bench preload words.
    assign ram_out = mem[ram_address];
    always @(posedge clk) begin
        if (ram_load) mem[ram_address] <= ram_in;
        if (pk_en) mem[pk_addr] <= pk_data;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare process: every cycle the DUT outputs must equal the next predicted entry, or idle zeros.
    always @(negedge clk) begin
        if (chk_en) begin
            cmp_act = {busy, done, ram_load, ram_address, ram_in};
            if (exp_q.size() > 0) cmp_exp = exp_q.pop_front();
            else cmp_exp = '0;
            check("outputs", 32'(cmp_act), 32'(cmp_exp));
            cyc++;
            if (done) begin
                done_cyc = cyc;
                done_cnt++;
            end
            if (busy) begin
                busy_cnt++;
                addr_log.push_back(ram_address);
            end
            if (ram_load) load_cnt++;
        end
    end

    task automatic poke(input logic [8:0] a, input logic [15:0] d);
        pk_en   = 1'b1;
        pk_addr = a;
        pk_data = d;
        ref_mem[a] = d;
        @(posedge clk);
        #1 pk_en = 1'b0;
    endtask

    task automatic mem_check(input string name);
        int bad = 0;
        for (int i = 0; i < 512; i++) begin
            if (mem[i] !== ref_mem[i]) bad++;
        end
        check(name, 32'(bad), 32'd0);
    endtask

    // Issue one request; rc>0 asserts reset during cycle rc of the transfer.
    task automatic do_op(input logic [8:0] s, input logic [8:0] d, input logic [9:0] l,
                         input logic f, input logic [15:0] fv, input int rc);
        int   n;
        int   c;
        bit   fm;
        exp_t e;
        logic [8:0] a;
        @(negedge clk);
        start = 1'b1; src = s; dst = d; len = l; fill = f; fill_value = fv;
        @(posedge clk);
        #1;
        start = 1'b0;
        src = 9'($urandom); dst = 9'($urandom); len = 10'($urandom);
        fill = 1'($urandom); fill_value = 16'($urandom);
        cyc = 0; done_cyc = 0; done_cnt = 0; busy_cnt = 0; load_cnt = 0;
        addr_log.delete();
        n  = (l > 10'd512) ? 512 : int'(l);
        fm = FILL_EN && f;
        c  = 0;
        for (int j = 0; j < n; j++) begin
            if (fm) begin
                a = d + 9'(j);
                c++;
                e = '{busy: 1'b1, done: 1'b0, load: 1'b1, addr: a, din: fv};
                if (rc == 0 || c <= rc) begin
                    exp_q.push_back(e);
                    ref_mem[a] = fv;
                end
            end else begin
                a = s + 9'(j);
                c++;
                e = '{busy: 1'b1, done: 1'b0, load: 1'b0, addr: a, din: 16'h0};
                if (rc == 0 || c <= rc) exp_q.push_back(e);
                e.din  = ref_mem[a];
                e.load = 1'b1;
                e.addr = d + 9'(j);
                c++;
                if (rc == 0 || c <= rc) begin
                    exp_q.push_back(e);
                    ref_mem[e.addr] = e.din;
                end
            end
        end
        c++;
        e = '{busy: 1'b0, done: 1'b1, load: 1'b0, addr: 9'h0, din: 16'h0};
        if (rc == 0) begin
            exp_q.push_back(e);
            repeat (c) @(posedge clk);
        end else begin
            repeat (rc - 1) @(posedge clk);
            #1 reset = 1'b1;
            @(posedge clk);
            #1 reset = 1'b0;
            repeat (3) @(posedge clk);
        end
        #1;
        check("trace_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        logic [8:0] wrap_exp[6];
        wrap_exp = '{9'd510, 9'd1, 9'd511, 9'd2, 9'd0, 9'd3};
        reset = 1'b1; start = 1'b0; src = '0; dst = '0; len = '0;
        fill = 1'b0; fill_value = '0; pk_en = 1'b0; pk_addr = '0; pk_data = '0;
        cyc = 0; done_cyc = 0; done_cnt = 0; busy_cnt = 0; load_cnt = 0;
        @(posedge clk);
        #1 chk_en = 1'b1;
        @(negedge clk);
        check("reset_outputs", 32'({busy, done, ram_load, ram_address, ram_in}), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        for (int i = 0; i < 512; i++) poke(9'(i), 16'($urandom));

        // Basic copy
        for (int i = 0; i < 4; i++) poke(9'(10 + i), 16'(i + 1));
        do_op(9'd10, 9'd100, 10'd4, 1'b0, 16'h0, 0);
        check("basic_done_cycle", 32'(done_cyc), 32'd9);
        check("basic_busy_cycles", 32'(busy_cnt), 32'd8);
        for (int i = 0; i < 4; i++) check("basic_word", 32'(mem[100 + i]), 32'(i + 1));
        mem_check("basic_mem");

        // Wrap around the top of memory
        poke(9'd510, 16'hAAAA); poke(9'd511, 16'hBBBB); poke(9'd0, 16'hCCCC);
        do_op(9'd510, 9'd1, 10'd3, 1'b0, 16'h0, 0);
        check("wrap_addr_count", 32'(addr_log.size()), 32'd6);
        for (int i = 0; i < 6 && i < addr_log.size(); i++)
            check("wrap_addr", 32'(addr_log[i]), 32'(wrap_exp[i]));
        check("wrap_m1", 32'(mem[1]), 32'hAAAA);
        check("wrap_m2", 32'(mem[2]), 32'hBBBB);
        check("wrap_m3", 32'(mem[3]), 32'hCCCC);
        mem_check("wrap_mem");

        // Zero length
        do_op(9'd7, 9'd200, 10'd0, 1'b0, 16'h0, 0);
        check("zero_done_cycle", 32'(done_cyc), 32'd1);
        check("zero_loads", 32'(load_cnt), 32'd0);
        check("zero_busy", 32'(busy_cnt), 32'd0);
        mem_check("zero_mem");

        // Start pulse while busy is ignored
        fork
            do_op(9'd50, 9'd300, 10'd8, 1'b0, 16'h0, 0);
            begin
                repeat (4) @(posedge clk);
                #2;
                start = 1'b1; src = 9'd0; dst = 9'd400; len = 10'd5;
                @(posedge clk);
                #1 start = 1'b0;
            end
        join
        check("ignored_done_count", 32'(done_cnt), 32'd1);
        repeat (4) @(posedge clk);
        #1 check("ignored_no_restart", 32'(busy_cnt), 32'd16);
        mem_check("ignored_mem");

        // Overlapping forward copy propagates the first word
        for (int i = 0; i < 4; i++) poke(9'(i), 16'(5 + i));
        do_op(9'd0, 9'd1, 10'd3, 1'b0, 16'h0, 0);
        for (int i = 0; i < 4; i++) check("overlap_word", 32'(mem[i]), 32'd5);
        mem_check("overlap_mem");

        // Reset in cycle 5 of a 6-word copy
        do_op(9'd20, 9'd40, 10'd6, 1'b0, 16'h0, 5);
        check("reset_no_done", 32'(done_cnt), 32'd0);
        check("reset_loads", 32'(load_cnt), 32'd2);
        mem_check("reset_mem");

        // Fill request (a copy when the fill feature is not built)
        do_op(9'd300, 9'd508, 10'd6, 1'b1, 16'h1234, 0);
        if (FILL_EN) begin
            check("fill_done_cycle", 32'(done_cyc), 32'd7);
            for (int i = 0; i < 6; i++) check("fill_word", 32'(mem[(508 + i) % 512]), 32'h1234);
        end else begin
            check("fill_as_copy_done_cycle", 32'(done_cyc), 32'd13);
        end
        mem_check("fill_mem");

        // Oversized length saturates to the whole memory
        do_op(9'd3, 9'd260, 10'd700, 1'b0, 16'h0, 0);
        check("sat_done_cycle", 32'(done_cyc), 32'd1025);
        mem_check("sat_mem");

        // Randomized requests
        for (int k = 0; k < 30; k++) begin
            do_op(9'($urandom), 9'($urandom), 10'($urandom_range(0, 24)), 1'($urandom),
                  16'($urandom), 0);
            mem_check("rand_mem");
        end

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
